intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Phase scheduler for a two-approach intersection (main road, side road) with an optional pedestrian crossing phase. It drives the 3-bit lamp vectors of both approaches in the team's active-low lamp encoding and arbitrates green time between vehicle sensors and a pedestrian push-button. Timing is in seconds-scale ticks from an internal prescaler. The block sits between the sensor/button inputs and the lamp drivers.

## Interface
- TICK_DIV, 50_000_000: clk cycles per tick (1 s at 50 MHz); ≥2
- MIN_GREEN, 10: minimum green ticks, either approach; ≥1
- MAX_GREEN, 30: green ticks after which a pending request forces changeover; ≥MIN_GREEN
- YELLOW, 3: yellow ticks; ≥1
- ALL_RED, 2: all-red clearance ticks; ≥1
- PED_WALK, 8: walk ticks; ≥1
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- main_req  in  1  main-road vehicle sensor, level
- side_req  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, level or pulse
- main_led  out  3  main lamps, active-low {green,yellow,red}: red 3'b110, yellow 3'b101, green 3'b011
- side_led  out  3  side lamps, same encoding
- ped_walk  out  1  walk signal, 1 = walk
- ped_ack  out  1  one-cycle pulse when a pedestrian request is latched

## Operation
- States: CLEAR, MAIN_G, MAIN_Y, SIDE_G, SIDE_Y, PED. Lamps: MAIN_G main green; MAIN_Y main yellow; SIDE_G/SIDE_Y likewise; every other lamp red; ped_walk=1 only in PED.
- Reset: CLEAR, prev=PED, pending flags 0, prescaler and timer 0.
- side_pend: set when side_req=1 in any state but SIDE_G. ped_pend: set when ped_req=1. Each is cleared on entry to its green/walk phase. A request sampled on the entry cycle is absorbed (clear wins).
- ped_ack: 1 on the cycle after ped_pend goes 0→1. No pulse while ped_pend is already set.
- MAIN_G: rest phase. Leave to MAIN_Y when timer ≥ MIN_GREEN and (side_pend or ped_pend). With no pending request, stay indefinitely; the timer saturates. main_req only matters for the MAX_GREEN rule below.
- When main_req=1, main green extends past MIN_GREEN up to MAX_GREEN even with requests pending.
- SIDE_G: hold MIN_GREEN. Extend while side_req=1, up to MAX_GREEN. Then go to SIDE_Y.
- Yellow states: YELLOW ticks, then CLEAR. PED: PED_WALK ticks, then CLEAR.
- CLEAR: ALL_RED ticks, then choose the next phase by prev:
  - prev=MAIN: SIDE_G if side_pend, else PED if ped_pend, else MAIN_G.
  - prev=SIDE: PED if ped_pend, else MAIN_G.
  - prev=PED: MAIN_G.
- prev is updated on entry to MAIN_G, SIDE_G or PED.

## Timing
- Prescaler counts 0..TICK_DIV-1. The tick is the cycle at TICK_DIV-1.
- Prescaler and phase timer both zero on every state change. A phase of N ticks therefore lasts exactly N·TICK_DIV cycles.
- Transitions happen on the edge where tick=1 and the timer reaches its limit.
- Outputs are registered and update on the same edge as the state register. There is no combinational input→output path.
- Input→pending latency: 1 cycle. Inputs are synchronous to clk; synchronizers are external.
- Timer width is clog2(max(MAX_GREEN, YELLOW, ALL_RED, PED_WALK)+1). Prescaler width is clog2(TICK_DIV).
- rst_n low at any time, including mid-phase: immediately main_led=side_led=3'b110, ped_walk=0, ped_ack=0, all pending cleared. First green is MAIN_G after ALL_RED·TICK_DIV cycles from release.

## Configuration
- PED_PHASE_EN defined: PED state, ped_pend and ped_ack logic present as above.
- PED_PHASE_EN undefined: PED state absent and ped_req ignored. ped_walk and ped_ack are tied 0. CLEAR choice is side/main alternation only.

## Structure
- intersection_pkg: state encoding, lamp constants LAMP_RED/LAMP_YELLOW/LAMP_GREEN, prev-phase encoding.
- Sub-module tick_prescaler (param DIV; ports clk, rst_n, clr, tick) isolates the divider.

## Test plan
Parameters: TICK_DIV=4, MIN_GREEN=3, MAX_GREEN=6, YELLOW=2, ALL_RED=1, PED_WALK=2.
- Reset release, no requests -> all red for 4 cycles; then main_led=3'b011 held for 1000 cycles; side_led=3'b110 throughout.
- side_req pulse 5 cycles into MAIN_G, main_req=0 -> MAIN_G lasts 12 cycles, MAIN_Y 8, CLEAR 4, SIDE_G 12, SIDE_Y 8, CLEAR 4, back to MAIN_G.
- side_req held high -> SIDE_G lasts exactly 24 cycles. side_req high plus main_req high -> MAIN_G lasts 24 cycles.
- ped_req pulse during MAIN_G -> ped_ack high exactly 1 cycle. Then MAIN_Y, CLEAR, ped_walk=1 for 8 cycles with both leds 3'b110, then CLEAR, MAIN_G. A second ped_req before PED gives no extra ack.
- side_req and ped_req together -> order SIDE_G, SIDE_Y, CLEAR, PED, CLEAR, MAIN_G.
- rst_n low mid SIDE_G -> same cycle both leds 3'b110, ped_walk 0. After release, MAIN_G after 4 cycles; the side request is not served.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared encodings for the intersection scheduler: phase states, lamp codes
// (active-low {green,yellow,red}) and the last-served-phase marker.
package intersection_pkg;

   typedef enum logic [2:0] {
      ST_CLEAR,
      ST_MAIN_G,
      ST_MAIN_Y,
      ST_SIDE_G,
      ST_SIDE_Y,
      ST_PED
   } state_t;

   typedef enum logic [1:0] {
      PREV_MAIN,
      PREV_SIDE,
      PREV_PED
   } prev_t;

   localparam logic [2:0] LAMP_RED    = 3'b110;
   localparam logic [2:0] LAMP_YELLOW = 3'b101;
   localparam logic [2:0] LAMP_GREEN  = 3'b011;

   function automatic logic [2:0] main_lamp(input state_t s);
      case (s)
         ST_MAIN_G: return LAMP_GREEN;
         ST_MAIN_Y: return LAMP_YELLOW;
         default:   return LAMP_RED;
      endcase
   endfunction

   function automatic logic [2:0] side_lamp(input state_t s);
      case (s)
         ST_SIDE_G: return LAMP_GREEN;
         ST_SIDE_Y: return LAMP_YELLOW;
         default:   return LAMP_RED;
      endcase
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/intersection_scheduler_tick_prescaler.sv
// Seconds-scale tick divider: counts 0..DIV-1 and flags the last count.
// clr restarts the count so every phase begins on a fresh tick period.
module tick_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int W = $clog2(DIV);

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase scheduler with registered lamp outputs.
// Define PED_PHASE_EN to build the pedestrian walk phase; otherwise ped_req is ignored.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_CLEAR  | all-red clearance, then pick next phase from prev
// ST_MAIN_G | main green, rest phase
// ST_MAIN_Y | main yellow
// ST_SIDE_G | side green, extended by side_req up to MAX_GREEN
// ST_SIDE_Y | side yellow
// ST_PED    | pedestrian walk, all vehicle lamps red
module intersection_scheduler
   import intersection_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int MIN_GREEN = 10,
   parameter int MAX_GREEN = 30,
   parameter int YELLOW    = 3,
   parameter int ALL_RED   = 2,
   parameter int PED_WALK  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       main_req,
   input  logic       side_req,
   input  logic       ped_req,
   output logic [2:0] main_led,
   output logic [2:0] side_led,
   output logic       ped_walk,
   output logic       ped_ack
);

   localparam int TMAX = max4(MAX_GREEN, YELLOW, ALL_RED, PED_WALK);
   localparam int TW   = $clog2(TMAX + 1);

   state_t        state, state_nx;
   prev_t         prev, prev_nx;
   logic [TW-1:0] timer;
   logic [TW:0]   tcnt;
   logic          tick, phase_chg;
   logic          side_pend, side_pend_nx, ped_pend;
   logic          at_min, at_max, at_yel, at_clr, at_walk;

   tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (phase_chg),
      .tick  (tick)
   );

   // tcnt is the tick count the phase will have completed once this tick lands
   assign tcnt    = {1'b0, timer} + (TW+1)'(1);
   assign at_min  = tick && (tcnt >= (TW+1)'(MIN_GREEN));
   assign at_max  = tick && (tcnt >= (TW+1)'(MAX_GREEN));
   assign at_yel  = tick && (tcnt >= (TW+1)'(YELLOW));
   assign at_clr  = tick && (tcnt >= (TW+1)'(ALL_RED));
   assign at_walk = tick && (tcnt >= (TW+1)'(PED_WALK));

   assign phase_chg = (state_nx != state);

   always_comb begin
      state_nx = state;
      case (state)
         ST_CLEAR: begin
            if (at_clr) begin
               if (prev == PREV_MAIN && side_pend)
                  state_nx = ST_SIDE_G;
               else if (prev != PREV_PED && ped_pend)
                  state_nx = ST_PED;
               else
                  state_nx = ST_MAIN_G;
            end
         end
         ST_MAIN_G: if (at_min && (side_pend || ped_pend) && (!main_req || at_max))
            state_nx = ST_MAIN_Y;
         ST_MAIN_Y: if (at_yel) state_nx = ST_CLEAR;
         ST_SIDE_G: if (at_min && (!side_req || at_max)) state_nx = ST_SIDE_Y;
         ST_SIDE_Y: if (at_yel) state_nx = ST_CLEAR;
         ST_PED:    if (at_walk) state_nx = ST_CLEAR;
         default:   state_nx = ST_CLEAR;
      endcase
   end

   // Entry to a served phase records it and absorbs its own pending request
   always_comb begin
      prev_nx      = prev;
      side_pend_nx = side_pend | (side_req && state != ST_SIDE_G);
      if (phase_chg) begin
         case (state_nx)
            ST_MAIN_G: prev_nx = PREV_MAIN;
            ST_SIDE_G: begin
               prev_nx      = PREV_SIDE;
               side_pend_nx = 1'b0;
            end
            ST_PED:    prev_nx = PREV_PED;
            default:   prev_nx = prev;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_CLEAR;
         prev      <= PREV_PED;
         timer     <= '0;
         side_pend <= 1'b0;
         main_led  <= LAMP_RED;
         side_led  <= LAMP_RED;
      end else begin
         state     <= state_nx;
         prev      <= prev_nx;
         side_pend <= side_pend_nx;
         if (phase_chg)
            timer <= '0;
         else if (tick && timer != TW'(TMAX))
            timer <= timer + TW'(1);
         main_led  <= main_lamp(state_nx);
         side_led  <= side_lamp(state_nx);
      end
   end

`ifdef PED_PHASE_EN
   logic ped_pend_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ped_pend   <= 1'b0;
         ped_pend_d <= 1'b0;
         ped_ack    <= 1'b0;
         ped_walk   <= 1'b0;
      end else begin
         if (phase_chg && state_nx == ST_PED)
            ped_pend <= 1'b0;
         else if (ped_req)
            ped_pend <= 1'b1;
         ped_pend_d <= ped_pend;
         ped_ack    <= ped_pend & ~ped_pend_d;
         ped_walk   <= (state_nx == ST_PED);
      end
   end
`else
   logic unused_ped;
   assign unused_ped = ped_req;
   assign ped_pend   = 1'b0;
   assign ped_walk   = 1'b0;
   assign ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: phase-length table, corner sequences and
// a randomized run against a tick-arithmetic reference model.
module tb_intersection_scheduler;

   localparam int TD = 4, MING = 3, MAXG = 6, YEL = 2, AR = 1, PW = 2;
   localparam logic [2:0] G = 3'b011, Y = 3'b101, R = 3'b110;
`ifdef PED_PHASE_EN
   localparam bit PED_EN = 1'b1;
`else
   localparam bit PED_EN = 1'b0;
`endif

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       main_req = 1'b0, side_req = 1'b0, ped_req = 1'b0;
   logic [2:0] main_led, side_led;
   logic       ped_walk, ped_ack;
   int         tests = 0, fails = 0, acks = 0;

   intersection_scheduler #(
      .TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
      .YELLOW(YEL), .ALL_RED(AR), .PED_WALK(PW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .main_req(main_req), .side_req(side_req),
      .ped_req(ped_req), .main_led(main_led), .side_led(side_led),
      .ped_walk(ped_walk), .ped_ack(ped_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp_v);
      tests++;
      if (act != exp_v) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endtask

   // One record per expected phase: lamps, length in cycles, and the
   // request levels {main,side,ped} held plus a one-cycle pulse at index pat.
   typedef struct {
      string      nm;
      logic [2:0] em;
      logic [2:0] es;
      logic       ew;
      int         len;
      logic [2:0] hold;
      logic [2:0] pulse;
      int         pat;
   } rec_t;

   rec_t recs[$];

   function automatic rec_t mk(input string nm, input logic [2:0] em, input logic [2:0] es,
                               input logic ew, input int len, input logic [2:0] hold,
                               input logic [2:0] pulse, input int pat);
      rec_t r;
      r.nm = nm; r.em = em; r.es = es; r.ew = ew; r.len = len;
      r.hold = hold; r.pulse = pulse; r.pat = pat;
      return r;
   endfunction

   task automatic run_phase(input rec_t rc, input int idx);
      int n = 0;
      while (n < rc.len + 40) begin
         if (!(main_led == rc.em && side_led == rc.es && ped_walk == rc.ew)) break;
         if (ped_ack) acks++;
         {main_req, side_req, ped_req} = rc.hold | ((n == rc.pat) ? rc.pulse : 3'b000);
         n++;
         @(negedge clk);
      end
      {main_req, side_req, ped_req} = 3'b000;
      check($sformatf("%s[%0d] length", rc.nm, idx), n, rc.len);
   endtask

   task automatic hold_main(input int n, input string nm, input bit rnd);
      int bad = 0;
      for (int i = 0; i < n; i++) begin
         if (main_led != G || side_led != R || ped_walk || ped_ack) bad++;
         main_req = rnd ? 1'($urandom_range(1)) : 1'b0;
         ped_req  = (rnd && !PED_EN) ? 1'($urandom_range(1)) : 1'b0;
         side_req = 1'b0;
         @(negedge clk);
      end
      main_req = 1'b0;
      ped_req  = 1'b0;
      check(nm, bad, 0);
   endtask

   // Reference model: phase name plus cycles spent in it; ticks = cycles / TD.
   typedef enum int {P_CLR, P_MG, P_MY, P_SG, P_SY, P_PED} ph_t;
   ph_t m_ph, m_prev;
   int  m_cyc;
   bit  m_sp, m_pp, m_pp_d, m_ack;

   task automatic model_reset();
      m_ph = P_CLR; m_prev = P_PED; m_cyc = 0;
      m_sp = 0; m_pp = 0; m_pp_d = 0; m_ack = 0;
   endtask

   task automatic model_step(input bit mr, input bit sr, input bit pr);
      ph_t nx;
      int  t;
      nx = m_ph;
      m_cyc++;
      t = m_cyc / TD;
      if (m_cyc % TD == 0) begin
         case (m_ph)
            P_CLR: if (t >= AR) begin
               if (m_prev == P_MG && m_sp)       nx = P_SG;
               else if (m_prev != P_PED && m_pp) nx = P_PED;
               else                              nx = P_MG;
            end
            P_MG:  if (t >= MING && (m_sp || m_pp) && (!mr || t >= MAXG)) nx = P_MY;
            P_MY:  if (t >= YEL) nx = P_CLR;
            P_SG:  if (t >= MING && (!sr || t >= MAXG)) nx = P_SY;
            P_SY:  if (t >= YEL) nx = P_CLR;
            P_PED: if (t >= PW) nx = P_CLR;
            default: nx = P_CLR;
         endcase
      end
      m_ack  = m_pp && !m_pp_d;
      m_pp_d = m_pp;
      m_sp   = (nx == P_SG && m_ph != P_SG) ? 1'b0 : (m_sp | (sr && m_ph != P_SG));
      m_pp   = (nx == P_PED && m_ph != P_PED) ? 1'b0 : (m_pp | (pr && PED_EN));
      if (nx != m_ph) begin
         m_cyc = 0;
         if (nx == P_MG || nx == P_SG || nx == P_PED) m_prev = nx;
      end
      m_ph = nx;
   endtask

   function automatic logic [7:0] model_out();
      logic [2:0] ml, sl;
      ml = (m_ph == P_MG) ? G : (m_ph == P_MY) ? Y : R;
      sl = (m_ph == P_SG) ? G : (m_ph == P_SY) ? Y : R;
      return {ml, sl, (m_ph == P_PED), m_ack};
   endfunction

   initial begin
      int n;
      int rf;
      bit mr, sr;

      repeat (3) @(negedge clk);
      check("reset main_led", int'(main_led), int'(R));
      check("reset side_led", int'(side_led), int'(R));
      check("reset ped_walk", int'(ped_walk), 0);
      check("reset ped_ack", int'(ped_ack), 0);

      recs.push_back(mk("clear_after_reset", R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("main_g_side_pulse", G, R, 0, 12, 3'b000, 3'b010,  5));
      recs.push_back(mk("main_y",            Y, R, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_g_min",        R, G, 0, 12, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_y",            R, Y, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("main_g_max_ext",    G, R, 0, 24, 3'b110, 3'b000, -1));
      recs.push_back(mk("main_y",            Y, R, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_g_max_ext",    R, G, 0, 24, 3'b010, 3'b000, -1));
      recs.push_back(mk("side_y",            R, Y, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("main_g_late_req",   G, R, 0, 24, 3'b000, 3'b010, 20));
      recs.push_back(mk("main_y",            Y, R, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_g_one_ext",    R, G, 0, 16, 3'b000, 3'b010, 11));
      recs.push_back(mk("side_y",            R, Y, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
`ifdef PED_PHASE_EN
      recs.push_back(mk("main_g_ped",        G, R, 0, 12, 3'b000, 3'b001,  1));
      recs.push_back(mk("main_y_ped_again",  Y, R, 0,  8, 3'b000, 3'b001,  2));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("ped_walk",          R, R, 1,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("main_g_side_ped",   G, R, 0, 12, 3'b000, 3'b011,  0));
      recs.push_back(mk("main_y",            Y, R, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_g_before_ped", R, G, 0, 12, 3'b000, 3'b000, -1));
      recs.push_back(mk("side_y",            R, Y, 0,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
      recs.push_back(mk("ped_after_side",    R, R, 1,  8, 3'b000, 3'b000, -1));
      recs.push_back(mk("clear",             R, R, 0,  4, 3'b000, 3'b000, -1));
`endif

      rst_n = 1'b1;
      foreach (recs[i]) run_phase(recs[i], i);
`ifdef PED_PHASE_EN
      check("ped_ack pulses", acks, 2);
`else
      check("ped_ack pulses", acks, 0);
`endif

      hold_main(1000, "main green rest hold", 1'b1);

      side_req = 1'b1;
      @(negedge clk);
      side_req = 1'b0;
      n = 1;
      while (main_led != Y && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("saturated main_g leaves within one tick", int'(n >= 2 && n <= 5), 1);
      n = 0;
      while (side_led != G && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("yellow+clear before side green", n, 12);

      repeat (3) @(negedge clk);
      side_req = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("async reset main_led", int'(main_led), int'(R));
      check("async reset side_led", int'(side_led), int'(R));
      check("async reset ped_walk", int'(ped_walk), 0);
      repeat (2) @(negedge clk);
      side_req = 1'b0;
      rst_n    = 1'b1;
      run_phase(mk("clear_after_mid_reset", R, R, 0, 4, 3'b000, 3'b000, -1), 0);
      hold_main(40, "side request dropped by reset", 1'b0);

      @(negedge clk);
      rst_n = 1'b0;
      {main_req, side_req, ped_req} = 3'b000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mr = 0; sr = 0; rf = 0;
      for (int c = 0; c < 4000 && rf < 20; c++) begin
         tests++;
         if ({main_led, side_led, ped_walk, ped_ack} != model_out()) begin
            fails++;
            rf++;
            $display("FAIL random cycle %0d: got %b, expected %b", c,
                     {main_led, side_led, ped_walk, ped_ack}, model_out());
         end
         if ($urandom_range(15) == 0) mr = ~mr;
         if ($urandom_range(11) == 0) sr = ~sr;
         main_req = mr;
         side_req = sr;
         ped_req  = ($urandom_range(39) == 0);
         model_step(main_req, side_req, ped_req);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
